// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache.
//   state_e      controller states
//   index_width  line-index width for a given line count
//   tag_width    tag width for a given line count and block-address width
//   merge_word   byte-merge a 32-bit store word into a 256-bit line
//   get_word     extract one 32-bit word from a 256-bit line
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    localparam int WORD_W = 32;
    localparam int LINE_W = 256;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines, input int blk_aw);
        return blk_aw - $clog2(lines);
    endfunction

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        word,
        input logic [WORD_W-1:0] wdata,
        input logic [3:0]        wstrb
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[int'(word) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [WORD_W-1:0] get_word(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        word
    );
        return line[int'(word) * 32 +: 32];
    endfunction

endpackage

// File: rtl/dcache_direct_if.sv
// Bus bundle between the cache, the load/store port and block memory.
//   slave  : cache side (accepts CPU requests, issues memory strobes)
//   master : environment side (CPU driver + block memory)
interface dcache_direct_if #(
    parameter int BLK_AW = 11
);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_write;
    logic [31:0]       cpu_req_addr;
    logic [31:0]       cpu_req_wdata;
    logic [3:0]        cpu_req_wstrb;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_resp_rdata;
    logic [BLK_AW-1:0] mem_addr;
    logic [255:0]      mem_write_block;
    logic              mem_read;
    logic              mem_write;
    logic [255:0]      mem_read_block;

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
               cpu_req_wstrb, mem_read_block,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_addr,
               mem_write_block, mem_read, mem_write
    );

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
               cpu_req_wstrb, mem_read_block,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_addr,
               mem_write_block, mem_read, mem_write
    );
endinterface

// File: rtl/dcache_store.sv
// Line storage: tag and data arrays plus valid/dirty flop vectors.
//   clock      : rising-edge clock
//   clr_i      : synchronous clear of all valid and dirty bits
//   rd_idx_i   : asynchronous read index -> rd_valid_o/rd_dirty_o/rd_tag_o/rd_data_o
//   wr_*_i     : one synchronous write port; a write always marks the line
//                valid and loads its dirty bit from wr_dirty_i
module dcache_store #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 7
) (
    input  logic             clock,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [255:0]     rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [255:0]     wr_data_i,
    input  logic             wr_dirty_i
);

    logic [TAG_W-1:0] tag_q   [LINES];
    logic [255:0]     data_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (clr_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : CPU load/store request/response and block-memory strobes
// Hits answer in the cycle after accept; misses optionally write back the
// dirty victim, refill the line, then answer from the RESP state.
//
// state     | meaning
// IDLE      | accepting requests, hits serviced here
// WRITEBACK | mem_write held MEM_LATENCY cycles with the dirty victim
// REFILL    | mem_read held MEM_LATENCY cycles, line captured on the last one
// RESP      | latched request applied to the filled line, response pulsed
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 2,
    parameter int BLK_AW      = 11
) (
    input  logic           clock,
    input  logic           reset,
    dcache_direct_if.slave bus
);

    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(LINES, BLK_AW);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_en_q;

    logic             req_write_q;
    logic [2:0]       req_word_q;
    logic [IDX_W-1:0] req_idx_q;
    logic [TAG_W-1:0] req_tag_q;
    logic [31:0]      req_wdata_q;
    logic [3:0]       req_wstrb_q;

    logic [2:0]       in_word;
    logic [IDX_W-1:0] in_idx;
    logic [TAG_W-1:0] in_tag;
    logic             unused_addr_bits;

    logic             accept;
    logic             hit;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid, rd_dirty;
    logic [TAG_W-1:0] rd_tag;
    logic [255:0]     rd_data;
    logic [255:0]     merged_in, merged_req, fill_line;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [255:0]     wr_data;
    logic             wr_dirty;

    // Address bits above the block address alias; byte offset is ignored.
    assign in_word = bus.cpu_req_addr[4:2];
    assign in_idx  = bus.cpu_req_addr[5 +: IDX_W];
    assign in_tag  = bus.cpu_req_addr[5 + IDX_W +: TAG_W];
    assign unused_addr_bits = ^{bus.cpu_req_addr[1:0], bus.cpu_req_addr[31:BLK_AW + 5]};

    // The array is read at the incoming index while idle, otherwise at the
    // latched index (victim for writeback, filled line for the response).
    assign rd_idx = (state_q == ST_IDLE) ? in_idx : req_idx_q;

    dcache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clock      (clock),
        .clr_i      (reset),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en && !reset),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data),
        .wr_dirty_i (wr_dirty)
    );

    assign bus.cpu_req_ready   = ready_en_q && (state_q == ST_IDLE);
    assign bus.cpu_resp_valid  = resp_valid_q;
    assign bus.cpu_resp_rdata  = rdata_q;
    assign bus.mem_write       = (state_q == ST_WRITEBACK);
    assign bus.mem_read        = (state_q == ST_REFILL);
    assign bus.mem_write_block = (state_q == ST_WRITEBACK) ? rd_data : '0;
    assign bus.mem_addr        = (state_q == ST_WRITEBACK) ? {rd_tag, req_idx_q}    :
                                 (state_q == ST_REFILL)    ? {req_tag_q, req_idx_q} :
                                 '0;

    assign accept     = bus.cpu_req_valid && bus.cpu_req_ready;
    assign hit        = rd_valid && (rd_tag == in_tag);
    assign merged_in  = merge_word(rd_data, in_word, bus.cpu_req_wdata, bus.cpu_req_wstrb);
    assign merged_req = merge_word(rd_data, req_word_q, req_wdata_q, req_wstrb_q);
    // Response word for a miss is formed from the incoming block so it can be
    // registered on the last refill cycle and shown during RESP.
    assign fill_line  = req_write_q ?
                        merge_word(bus.mem_read_block, req_word_q, req_wdata_q, req_wstrb_q) :
                        bus.mem_read_block;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        wr_en        = 1'b0;
        wr_idx       = req_idx_q;
        wr_tag       = req_tag_q;
        wr_data      = rd_data;
        wr_dirty     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        resp_valid_d = 1'b1;
                        if (bus.cpu_req_write) begin
                            wr_en    = 1'b1;
                            wr_idx   = in_idx;
                            wr_tag   = in_tag;
                            wr_data  = merged_in;
                            wr_dirty = 1'b1;
                            rdata_d  = get_word(merged_in, in_word);
                        end else begin
                            rdata_d  = get_word(rd_data, in_word);
                        end
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_REFILL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REFILL: begin
                if (cnt_q == '0) begin
                    wr_en        = 1'b1;
                    wr_data      = bus.mem_read_block;
                    wr_dirty     = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = get_word(fill_line, req_word_q);
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (req_write_q) begin
                    wr_en    = 1'b1;
                    wr_data  = merged_req;
                    wr_dirty = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            ready_en_q   <= 1'b0;
            req_write_q  <= 1'b0;
            req_word_q   <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            ready_en_q   <= 1'b1;
            if (accept) begin
                req_write_q <= bus.cpu_req_write;
                req_word_q  <= in_word;
                req_idx_q   <= in_idx;
                req_tag_q   <= in_tag;
                req_wdata_q <= bus.cpu_req_wdata;
                req_wstrb_q <= bus.cpu_req_wstrb;
            end
        end
    end

endmodule
